decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised RV64 decode stage between the fetch and execute pipeline registers.
- Extracts register addresses, drives the regfile read ports, generates all immediate formats (I/S/B/U/J), and detects load-use hazards.
- Captures the decoded result in an output pipeline register under a valid/ready handshake, with flush support.
- Generalises the earlier combinational decode: parametrised width, hazard stall, bubble insertion and a stall counter.

Parameters:
- XLEN, 64, datapath width of pc, register data and immediates.
- REG_AW, 5, register address width; must be at least 5.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  decode accepts the instruction this cycle
- in_pc  input  XLEN  pc of the fetched instruction
- in_instr  input  32  raw instruction
- ra1, ra2  output  REG_AW  regfile read addresses: in_instr[19:15] and in_instr[24:20], zero-extended
- rd1, rd2  input  XLEN  regfile read data for ra1/ra2
- ex_valid  input  1  execute stage holds a valid instruction
- ex_is_load  input  1  that instruction is a load
- ex_dst  input  REG_AW  its destination register
- flush  input  1  kill the decode register and the incoming instruction
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute accepts the bundle
- out_pc  output  XLEN  registered pc
- out_srca, out_srcb  output  XLEN  registered operands; x0 always reads 0
- out_imm  output  XLEN  sign-extended immediate
- out_dst  output  REG_AW  destination register; 0 for S/B formats
- out_opcode  output  7  instr[6:0]
- out_funct3  output  3  instr[14:12]
- out_funct7  output  7  instr[31:25]
- stall_cnt  output  CNT_W  cycles lost to load-use stalls, saturating

Behaviour:
- Reset: asynchronous. All registered outputs and stall_cnt go to 0, out_valid=0.
- Latency: one cycle from accept to out_valid.
- Register usage by opcode:
  - rs1 used by all formats except U/J.
  - rs2 used by R, S, B.
- hazard = in_valid & ex_valid & ex_is_load & (ex_dst!=0) & ((rs1 used & ex_dst==rs1) | (rs2 used & ex_dst==rs2)).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Register update, in priority order:
  1. flush: out_valid<=0.
  2. Else accept (in_valid & in_ready): load the bundle, out_valid<=1.
  3. Else if out_ready: out_valid<=0 (bubble; payload may hold stale data).
  4. Else hold all outputs unchanged. Payload must be stable while out_valid & !out_ready.
- Immediate by opcode, all sign-extended from instr[31] to XLEN:
  - I (0000011, 0010011, 0011011, 1100111, 1110011): instr[31:20].
  - S (0100011): {instr[31:25], instr[11:7]}.
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (0110111, 0010111): {instr[31:12], 12'b0}.
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode: imm=0.
- out_dst = instr[11:7], forced to 0 for S and B formats.
- stall_cnt increments by 1 in each cycle with hazard=1 and flush=0, and saturates at all-ones.
- Flush and hazard together: flush wins; the hazard is not counted.
- Reset asserted mid-stall: the pending instruction is dropped.

Optional Feature:
- Macro: DECODE_FWD_EN.
- When defined, adds ports:
  - wb_valid  input  1
  - wb_dst  input  REG_AW
  - wb_data  input  XLEN
- With the macro: if wb_valid & wb_dst!=0 & wb_dst==ra1, srca captures wb_data instead of rd1. The same rule applies to srcb/ra2. This is a same-cycle writeback bypass.
- Without the macro: operands come only from rd1/rd2 (x0 still forced to 0).

Test Plan:
- Reset, then `addi x5,x1,-1` (0xFFF08293), rd1=7, out_ready=1 -> next cycle: out_valid=1, out_srca=7, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_dst=5.
- `sd x2,8(x3)` (0x0021B423) -> out_imm=8, out_dst=0. `jal x1,-4` (0xFFDFF0EF) -> out_imm=-4.
- ex_valid=1, ex_is_load=1, ex_dst=2, in_instr `add x3,x2,x4` for 2 cycles -> in_ready=0, bubble with out_valid=0, stall_cnt=2. Accept occurs when ex_valid drops.
- out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0 and payload unchanged.
- flush together with in_valid and hazard -> in_ready=0, out_valid=0 next cycle, stall_cnt unchanged.
- DECODE_FWD_EN: wb_valid=1, wb_dst=1, wb_data=0x55, ra1=1, rd1=0x11 -> out_srca=0x55. Same stimulus with ra1=0 -> out_srca=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV64 decode stage: register address extraction, immediate generation, load-use
// hazard stall and a registered output bundle. Define DECODE_FWD_EN for the writeback bypass.
module decode_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    output logic [REG_AW-1:0] ra1,
    output logic [REG_AW-1:0] ra2,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_dst,
`ifdef DECODE_FWD_EN
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [XLEN-1:0]   wb_data,
`endif
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_srca,
    output logic [XLEN-1:0]   out_srcb,
    output logic [XLEN-1:0]   out_imm,
    output logic [REG_AW-1:0] out_dst,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    logic [6:0]        opcode;
    logic              is_r, is_i, is_s, is_b, is_u, is_j;
    logic              rs1_used, rs2_used;
    logic              hazard;
    logic              accept;
    logic [XLEN-1:0]   imm_d;
    logic [XLEN-1:0]   srca_d, srcb_d;
    logic [REG_AW-1:0] dst_d;

    assign opcode = in_instr[6:0];
    assign ra1    = REG_AW'(in_instr[19:15]);
    assign ra2    = REG_AW'(in_instr[24:20]);

    always_comb begin
        is_r = (opcode == OP_REG) || (opcode == OP_REG32);
        is_i = (opcode == OP_LOAD) || (opcode == OP_IMM) || (opcode == OP_IMM32) ||
               (opcode == OP_JALR) || (opcode == OP_SYSTEM);
        is_s = (opcode == OP_STORE);
        is_b = (opcode == OP_BRANCH);
        is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
        is_j = (opcode == OP_JAL);
    end

    assign rs1_used = !(is_u || is_j);
    assign rs2_used = is_r || is_s || is_b;

    always_comb begin
        imm_d = '0;
        if (is_i)
            imm_d = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        else if (is_s)
            imm_d = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (is_b)
            imm_d = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        else if (is_u)
            imm_d = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
        else if (is_j)
            imm_d = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
    end

    assign dst_d = (is_s || is_b) ? '0 : REG_AW'(in_instr[11:7]);

    // x0 is hardwired; the bypass, when built in, only ever targets a non-zero register.
    always_comb begin
        srca_d = (ra1 == '0) ? '0 : rd1;
        srcb_d = (ra2 == '0) ? '0 : rd2;
`ifdef DECODE_FWD_EN
        if (wb_valid && (wb_dst != '0) && (wb_dst == ra1))
            srca_d = wb_data;
        if (wb_valid && (wb_dst != '0) && (wb_dst == ra2))
            srcb_d = wb_data;
`endif
    end

    assign hazard = in_valid && ex_valid && ex_is_load && (ex_dst != '0) &&
                    ((rs1_used && (ex_dst == ra1)) || (rs2_used && (ex_dst == ra2)));

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the payload is frozen while valid is high and ready low.
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_srca   <= '0;
            out_srcb   <= '0;
            out_imm    <= '0;
            out_dst    <= '0;
            out_opcode <= '0;
            out_funct3 <= '0;
            out_funct7 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_pc     <= in_pc;
                out_srca   <= srca_d;
                out_srcb   <= srcb_d;
                out_imm    <= imm_d;
                out_dst    <= dst_d;
                out_opcode <= opcode;
                out_funct3 <= in_instr[14:12];
                out_funct7 <= in_instr[31:25];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a reference decoder feeding an expected-bundle queue.
module tb_decode_stage;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;
    localparam int BW     = 4*XLEN + REG_AW + 7 + 3 + 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic [REG_AW-1:0] ra1, ra2;
    logic [XLEN-1:0]   rd1, rd2;
    logic              ex_valid, ex_is_load;
    logic [REG_AW-1:0] ex_dst;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_dst;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc, out_srca, out_srcb, out_imm;
    logic [REG_AW-1:0] out_dst;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [CNT_W-1:0]  stall_cnt;

    logic [BW-1:0]     exp_q[$];
    logic              exp_valid;
    logic [CNT_W-1:0]  exp_cnt;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
`ifdef DECODE_FWD_EN
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
`endif
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_srca(out_srca), .out_srcb(out_srcb), .out_imm(out_imm),
        .out_dst(out_dst), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] ins);
        logic [XLEN-1:0] v;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: v = {{52{ins[31]}}, ins[31:20]};
            7'h23: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            7'h63: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            7'h37, 7'h17: v = {{32{ins[31]}}, ins[31:12], 12'h000};
            7'h6F: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [XLEN-1:0] ref_src(input logic [4:0] a, input logic [XLEN-1:0] rd);
        if (a == 5'd0) return '0;
`ifdef DECODE_FWD_EN
        if (wb_valid && wb_dst != 0 && wb_dst == a) return wb_data;
`endif
        return rd;
    endfunction

    function automatic logic [BW-1:0] ref_bundle();
        logic [REG_AW-1:0] d;
        d = (in_instr[6:0] == 7'h23 || in_instr[6:0] == 7'h63) ? '0 : in_instr[11:7];
        return {in_pc, ref_src(in_instr[19:15], rd1), ref_src(in_instr[24:20], rd2),
                ref_imm(in_instr), d, in_instr[6:0], in_instr[14:12], in_instr[31:25]};
    endfunction

    function automatic logic ref_hazard();
        logic [6:0] op;
        logic u1, u2;
        op = in_instr[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h3B || op == 7'h23 || op == 7'h63);
        return in_valid && ex_valid && ex_is_load && ex_dst != 0 &&
               ((u1 && ex_dst == in_instr[19:15]) || (u2 && ex_dst == in_instr[24:20]));
    endfunction

    // Called just after a falling edge with inputs settled; returns after the next one.
    task automatic step();
        logic hz, rdy;
        #1;
        hz  = ref_hazard();
        rdy = !flush && !hz && (!exp_valid || out_ready);
        chk("in_ready", BW'(in_ready), BW'(rdy));
        chk("ra1", BW'(ra1), BW'(in_instr[19:15]));
        chk("ra2", BW'(ra2), BW'(in_instr[24:20]));
        if (hz && !flush && exp_cnt != '1) exp_cnt++;
        if (flush) begin
            exp_q.delete();
            exp_valid = 1'b0;
        end else if (in_valid && rdy) begin
            if (exp_valid) void'(exp_q.pop_front());
            exp_q.push_back(ref_bundle());
            exp_valid = 1'b1;
        end else if (out_ready) begin
            if (exp_valid) void'(exp_q.pop_front());
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", BW'(out_valid), BW'(exp_valid));
        chk("stall_cnt", BW'(stall_cnt), BW'(exp_cnt));
        if (exp_valid) begin
            if (exp_q.size() == 0) chk("queue_empty", BW'(1), BW'(0));
            else chk("bundle", {out_pc, out_srca, out_srcb, out_imm, out_dst,
                                out_opcode, out_funct3, out_funct7}, exp_q[0]);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] snap_pc, snap_imm;
        logic [6:0] ops [10];
        ops = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        reset = 1'b1; in_valid = 0; in_pc = '0; in_instr = '0; rd1 = '0; rd2 = '0;
        ex_valid = 0; ex_is_load = 0; ex_dst = '0; flush = 0; out_ready = 1;
        wb_valid = 0; wb_dst = '0; wb_data = '0;
        exp_valid = 0; exp_cnt = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_stall_cnt", BW'(stall_cnt), BW'(0));
        chk("rst_out_imm", BW'(out_imm), BW'(0));
        chk("rst_out_pc", BW'(out_pc), BW'(0));
        reset = 1'b0;
        @(negedge clk);

        // addi x5,x1,-1
        in_valid = 1; in_pc = 64'h1000; in_instr = 32'hFFF08293; rd1 = 64'd7; rd2 = 64'd3;
        step();
        chk("addi_srca", BW'(out_srca), BW'(64'd7));
        chk("addi_imm", BW'(out_imm), BW'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("addi_dst", BW'(out_dst), BW'(5));
        // sd x2,8(x3)
        in_pc = 64'h1004; in_instr = 32'h0021B423;
        step();
        chk("sd_imm", BW'(out_imm), BW'(64'd8));
        chk("sd_dst", BW'(out_dst), BW'(0));
        // jal x1,-4
        in_pc = 64'h1008; in_instr = 32'hFFDFF0EF;
        step();
        chk("jal_imm", BW'(out_imm), BW'(64'hFFFF_FFFF_FFFF_FFFC));
        chk("jal_dst", BW'(out_dst), BW'(1));

        // load-use stall on add x3,x2,x4
        ex_valid = 1; ex_is_load = 1; ex_dst = 5'd2;
        in_pc = 64'h100C; in_instr = 32'h004101B3; rd1 = 64'h22; rd2 = 64'h44;
        step();
        step();
        chk("stall_two", BW'(stall_cnt), BW'(2));
        chk("stall_bubble", BW'(out_valid), BW'(0));
        ex_valid = 0;
        step();
        chk("stall_accept", BW'(out_srca), BW'(64'h22));

        // backpressure: payload frozen while out_ready is low
        out_ready = 0; in_pc = 64'h2000; in_instr = 32'h00500393;
        snap_pc = out_pc; snap_imm = out_imm;
        repeat (3) step();
        chk("hold_pc", BW'(out_pc), BW'(snap_pc));
        chk("hold_imm", BW'(out_imm), BW'(snap_imm));
        out_ready = 1;
        step();
        chk("release_pc", BW'(out_pc), BW'(64'h2000));

        // flush with hazard and in_valid: nothing accepted, nothing counted
        ex_valid = 1; ex_is_load = 1; ex_dst = 5'd2; flush = 1;
        in_pc = 64'h3000; in_instr = 32'h004101B3;
        step();
        chk("flush_valid", BW'(out_valid), BW'(0));
        chk("flush_cnt", BW'(stall_cnt), BW'(2));
        flush = 0;

        // reset asserted mid-stall drops the pending instruction
        step();
        #2 reset = 1;
        #1;
        chk("rst_mid_valid", BW'(out_valid), BW'(0));
        chk("rst_mid_cnt", BW'(stall_cnt), BW'(0));
        exp_q.delete(); exp_valid = 0; exp_cnt = '0;
        ex_valid = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);

`ifdef DECODE_FWD_EN
        wb_valid = 1; wb_dst = 5'd1; wb_data = 64'h55; rd1 = 64'h11;
        in_pc = 64'h4000; in_instr = 32'hFFF08293;
        step();
        chk("fwd_srca", BW'(out_srca), BW'(64'h55));
        in_instr = 32'hFFF00293;
        step();
        chk("fwd_x0", BW'(out_srca), BW'(0));
        wb_valid = 0;
`endif

        // random instructions across all formats with random backpressure and hazards
        for (int i = 0; i < 40; i++) begin
            in_instr  = {$urandom_range(0, 32'h01FF_FFFF), ops[$urandom_range(0, 9)]};
            in_pc     = {$urandom, $urandom};
            rd1       = {$urandom, $urandom};
            rd2       = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ex_valid  = ($urandom_range(0, 3) == 0);
            ex_is_load = 1;
            ex_dst    = REG_AW'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
